piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter; successor to the fixed 4-bit PISO.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per enabled cycle.
- Shift direction (MSB-first or LSB-first) is selectable per word.
- Flags frame completion with a one-cycle done pulse; sits between parallel datapath logic and serial link/pin drivers.

Parameters:
- WIDTH, 8, data word width; legal range is WIDTH >= 2.
- PARITY_ODD, 0, parity sense when the parity feature is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pi  input  WIDTH  parallel load data.
- ld_valid  input  1  load request.
- ld_ready  output  1  block can accept a load; combinational: rst high and state == IDLE.
- dir  input  1  direction, sampled at load: 0 = MSB-first, 1 = LSB-first.
- shift_en  input  1  shift-cycle enable (baud tick).
- so  output  1  serial data out, registered.
- so_valid  output  1  so carries a new bit this cycle.
- busy  output  1  state == SHIFT.
- done  output  1  one-cycle pulse after the final bit of a frame.
- rshift  output  WIDTH  shift register contents, for debug/observation.

Behaviour:
- Reset (rst = 0, async) sets state to IDLE and clears rshift, bit counter, dir_q, so, so_valid and done to 0. ld_ready = 0 while reset is asserted.
- A reset mid-frame discards the partial word. No done pulse is issued.
- States are IDLE and SHIFT.
- IDLE:
  - When ld_valid && ld_ready at a clock edge: rshift <= pi, dir_q <= dir, cnt <= 0, next state is SHIFT.
  - No shift occurs in the load cycle.
  - so holds its last value; so_valid is 0.
- SHIFT, with shift_en = 1:
  - so <= (dir_q ? rshift[0] : rshift[WIDTH-1]).
  - rshift shifts toward the output end, zero-filled (left shift for MSB-first, right shift for LSB-first).
  - so_valid <= 1 and cnt <= cnt + 1.
- SHIFT, with shift_en = 0:
  - rshift, cnt and so hold; so_valid <= 0.
- Frame end: the shift at cnt == WIDTH-1 (last data bit) also sets done <= 1 and next state IDLE. done is therefore coincident with so_valid of the last bit, for exactly one cycle.
- Latency: the first bit appears on so one cycle after the first enabled SHIFT cycle following the load.
- Minimum frame period is WIDTH+1 cycles: one load cycle plus WIDTH shifts. A new load is accepted the cycle after done.
- ld_valid while busy is ignored (ld_ready = 0). pi and dir are not sampled outside the handshake.
- cnt width is $clog2(WIDTH+1). The counter never wraps, since it is cleared at every load.
- shift_en asserted in IDLE has no effect.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - At load, a parity bit is registered: XOR of pi, XOR PARITY_ODD.
  - After the WIDTH data bits, one further enabled SHIFT cycle drives the parity bit on so with so_valid = 1.
  - done is asserted with the parity bit instead of the last data bit. Frame length is WIDTH+1 shifts.
  - cnt compares against WIDTH.
- Undefined: no parity register; frames are exactly WIDTH bits; PARITY_ODD is unused.

Decomposition:
- Package piso_pkg:
  - state enum typedef (IDLE, SHIFT).
  - Direction constants DIR_MSB = 0 and DIR_LSB = 1.
  - Default-width constant.
- One sub-module: piso_bit_counter.
  - Parametrised terminal-count counter with clear, enable and a last-bit flag output.
  - Instantiated once.
- The FSM and shift register stay in the top-level module.

Test Plan:
- WIDTH = 8, load 8'hA5 with dir = 0 and shift_en held at 1 -> so sequence 1,0,1,0,0,1,0,1 on 8 consecutive so_valid cycles. done pulses with the 8th bit. ld_ready returns to 1 on the next cycle.
- Load 8'h1E with dir = 1 -> so sequence 0,1,1,1,1,0,0,0. rshift reads 8'h00 after the last shift.
- Load 8'h1E (dir = 0) with shift_en toggling 1,0,1,0,... -> so_valid alternates and so holds during gaps. Bit sequence 0,0,0,1,1,1,1,0 is unchanged. done arrives after 8 enabled cycles.
- Pulse rst low after 3 shifts of 8'hFF -> all outputs go to 0 immediately with no done. A subsequent load of 8'h81 serialises 1,0,0,0,0,0,0,1 correctly.
- Hold ld_valid = 1 with pi = 8'h00 while shifting 8'hF0 -> the active frame is undisturbed. 8'h00 is loaded on the cycle after done, giving the back-to-back frame period = 9 cycles.
- With PISO_PARITY_EN and PARITY_ODD = 0, load 8'h07 -> 8 data bits then parity bit 1, with done on the 9th bit. With PARITY_ODD = 1 -> parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parametrised PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Terminal-count counter: synchronous clear, count enable, and a flag that
// is high while the count sits on the terminal value.
module piso_bit_counter #(
  parameter int TERM = 7,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(TERM));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a valid/ready load handshake and
// per-word direction. Optional trailing parity bit when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             dir,
  input  logic             shift_en,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rshift
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int TERM = WIDTH;
`else
  localparam int TERM = WIDTH - 1;
`endif

  state_t          state, nxt;
  logic            dir_q;
  logic            load, step, fin, last;
  logic            data_bit, bit_out;
  logic [CW-1:0]   cnt;

  assign ld_ready = rst && (state == IDLE);
  assign busy     = (state == SHIFT);
  assign load     = ld_valid && ld_ready;
  assign step     = (state == SHIFT) && shift_en;
  assign fin      = step && last;

  piso_bit_counter #(.TERM(TERM), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (step),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (load) nxt = SHIFT;
      SHIFT:   if (fin)  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign data_bit = dir_q ? rshift[0] : rshift[WIDTH-1];

`ifdef PISO_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      par_q <= 1'b0;
    else if (load) par_q <= (^pi) ^ PARITY_ODD;
  end

  // Data is fully drained once cnt reaches WIDTH; that slot carries parity.
  assign bit_out = (cnt == CW'(WIDTH)) ? par_q : data_bit;
`else
  assign bit_out = data_bit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rshift   <= '0;
      dir_q    <= DIR_MSB;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      so_valid <= step;
      done     <= fin;
      if (load) begin
        rshift <= pi;
        dir_q  <= dir;
      end else if (step) begin
        so     <= bit_out;
        rshift <= (dir_q == DIR_LSB) ? {1'b0, rshift[WIDTH-1:1]}
                                     : {rshift[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
